// File: rtl/vga_pkg.sv
// vga_pkg -- shared constants, bank FSM state type and colour-bar helper
// for the VGA pixel fetch path.
//   H_ACT / V_ACT  : active display size (640x480)
//   FRAME_PIXELS   : number of valid linear pixel addresses
//   PIX_W / ADDR_W : RGB444 pixel width, linear pixel address width
//   bank_state_t   : display-bank FSM states
//   bar_colour()   : eight vertical 80-pixel colour bars keyed by column
package vga_pkg;

  localparam int H_ACT        = 640;
  localparam int V_ACT        = 480;
  localparam int FRAME_PIXELS = H_ACT * V_ACT;
  localparam int PIX_W        = 12;
  localparam int ADDR_W       = 19;
  localparam int BAR_W        = H_ACT / 8;

  typedef enum logic [1:0] {
    SHOW,
    SWAP_PEND,
    FROZEN
  } bank_state_t;

  function automatic logic [PIX_W-1:0] bar_colour(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] col;
    logic [2:0]        bar;
    logic [PIX_W-1:0]  rgb;
    col = addr % ADDR_W'(H_ACT);
    bar = 3'(col / ADDR_W'(BAR_W));
    case (bar)
      3'd0:    rgb = 12'hFFF;
      3'd1:    rgb = 12'hFF0;
      3'd2:    rgb = 12'h0FF;
      3'd3:    rgb = 12'h0F0;
      3'd4:    rgb = 12'hF0F;
      3'd5:    rgb = 12'hF00;
      3'd6:    rgb = 12'h00F;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_bank_ctrl.sv
// vga_bank_ctrl -- double-buffer bank selection for the display side.
// A completed camera frame arms a swap; the swap happens only at the next
// falling edge of vga_vs so the displayed bank never changes mid-frame.
// freeze holds the current display bank and discards any armed swap.
// Ports:
//   vga_clk, sys_rst_n : clock, asynchronous active-low reset
//   vga_vs             : vertical sync, active-low pulse
//   wr_frame_done      : one-cycle pulse, write bank holds a full frame
//   freeze             : level, hold display bank while high
//   fb_bank            : bank being displayed (registered)
//   wr_bank            : bank the camera writes, always ~fb_bank
module vga_bank_ctrl
  import vga_pkg::*;
(
  input  logic vga_clk,
  input  logic sys_rst_n,
  input  logic vga_vs,
  input  logic wr_frame_done,
  input  logic freeze,
  output logic fb_bank,
  output logic wr_bank
);

  bank_state_t state;
  logic        vs_d;
  logic        vs_fall;

  assign vs_fall = vs_d & ~vga_vs;
  assign wr_bank = ~fb_bank;

  // freeze has priority over both arming and completing a swap.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= SHOW;
      vs_d    <= 1'b1;
      fb_bank <= 1'b0;
    end else begin
      vs_d <= vga_vs;
      case (state)
        SHOW: begin
          if (freeze)             state <= FROZEN;
          else if (wr_frame_done) state <= SWAP_PEND;
        end
        SWAP_PEND: begin
          if (freeze) begin
            state <= FROZEN;
          end else if (vs_fall) begin
            fb_bank <= ~fb_bank;
            state   <= SHOW;
          end
        end
        FROZEN: begin
          if (!freeze) state <= SHOW;
        end
        default: state <= SHOW;
      endcase
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch -- turns VGA driver pixel requests into frame-buffer
// reads and returns registered RGB444 pixels with fixed latency.
// Optional build macro TEST_PATTERN_EN adds pattern_sel, which replaces
// valid pixels with eight vertical colour bars and suppresses fb reads.
// Parameters:
//   RD_LAT       : frame-buffer read latency, 1..4 cycles
//   FRAME_PIXELS : number of valid pixel addresses
// Ports:
//   vga_clk, sys_rst_n : clock, asynchronous active-low reset
//   data_req           : pixel request (active region)
//   pixel_addr [18:0]  : linear pixel address
//   vga_vs             : vertical sync, active-low
//   pixel_data [11:0]  : registered RGB444 pixel, 0 when blank/out of range
//   fb_rd_en           : frame-buffer read strobe (combinational)
//   fb_rd_addr [19:0]  : {fb_bank, pixel_addr}
//   fb_rd_data [11:0]  : read data, valid RD_LAT cycles after fb_rd_en
//   wr_frame_done      : camera frame complete pulse
//   freeze             : hold display bank
//   fb_bank, wr_bank   : display bank and camera write bank
//   pattern_sel        : (TEST_PATTERN_EN only) select colour bars
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int RD_LAT       = 2,
  parameter int FRAME_PIXELS = vga_pkg::FRAME_PIXELS
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] pixel_addr,
  input  logic              vga_vs,
  output logic [PIX_W-1:0]  pixel_data,
  output logic              fb_rd_en,
  output logic [ADDR_W:0]   fb_rd_addr,
  input  logic [PIX_W-1:0]  fb_rd_data,
  input  logic              wr_frame_done,
  input  logic              freeze,
`ifdef TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              fb_bank,
  output logic              wr_bank
);

  localparam logic [31:0] PIX_LIMIT = 32'(FRAME_PIXELS);

  logic              in_range;
  logic              req_ok;
  logic [RD_LAT-1:0] valid_pipe;

  assign in_range   = ({{(32-ADDR_W){1'b0}}, pixel_addr} < PIX_LIMIT);
  assign req_ok     = data_req & in_range;
  assign fb_rd_addr = {fb_bank, pixel_addr};

`ifdef TEST_PATTERN_EN
  logic [RD_LAT-1:0] pat_pipe;
  logic [PIX_W-1:0]  colour_pipe [RD_LAT];

  assign fb_rd_en = req_ok & ~pattern_sel;
`else
  assign fb_rd_en = req_ok;
`endif

  // The valid pipe carries "in-range request" rather than the read strobe so
  // colour-bar pixels share the same slot timing; without the pattern option
  // the two are identical.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      valid_pipe <= '0;
      pixel_data <= '0;
`ifdef TEST_PATTERN_EN
      pat_pipe <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) colour_pipe[i] <= '0;
`endif
    end else begin
      valid_pipe[0] <= req_ok;
      for (int unsigned i = 1; i < RD_LAT; i++) valid_pipe[i] <= valid_pipe[i-1];
`ifdef TEST_PATTERN_EN
      pat_pipe[0]    <= pattern_sel;
      colour_pipe[0] <= bar_colour(pixel_addr);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pat_pipe[i]    <= pat_pipe[i-1];
        colour_pipe[i] <= colour_pipe[i-1];
      end
      if (!valid_pipe[RD_LAT-1])    pixel_data <= '0;
      else if (pat_pipe[RD_LAT-1])  pixel_data <= colour_pipe[RD_LAT-1];
      else                          pixel_data <= fb_rd_data;
`else
      pixel_data <= valid_pipe[RD_LAT-1] ? fb_rd_data : '0;
`endif
    end
  end

  vga_bank_ctrl u_bank_ctrl (
    .vga_clk       (vga_clk),
    .sys_rst_n     (sys_rst_n),
    .vga_vs        (vga_vs),
    .wr_frame_done (wr_frame_done),
    .freeze        (freeze),
    .fb_bank       (fb_bank),
    .wr_bank       (wr_bank)
  );

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 The module SHALL have parameter RD_LAT, default 2, giving the frame-buffer read latency in cycles; legal values are 1 to 4.
REQ-002 The module SHALL have parameter FRAME_PIXELS, default 307200 (640x480), giving the number of valid pixel addresses.
REQ-003 Port vga_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port data_req, input, 1 bit: pixel request from the VGA driver, high in the active region.
REQ-006 Port pixel_addr, input, 19 bits: linear address of the requested pixel.
REQ-007 Port vga_vs, input, 1 bit: vertical sync from the VGA driver, active-low pulse.
REQ-008 Port pixel_data, output, 12 bits: RGB444 pixel returned to the VGA driver.
REQ-009 Port fb_rd_en, output, 1 bit: frame-buffer read strobe.
REQ-010 Port fb_rd_addr, output, 20 bits: frame-buffer address, formed as {fb_bank, pixel_addr}.
REQ-011 Port fb_rd_data, input, 12 bits: read data, valid RD_LAT cycles after fb_rd_en.
REQ-012 Port wr_frame_done, input, 1 bit: one-cycle pulse from the camera write side when a full frame has been written into the write bank.
REQ-013 Port freeze, input, 1 bit: level signal; while high, the display bank is held and no bank swap occurs.
REQ-014 Port fb_bank, output, 1 bit: bank currently being displayed.
REQ-015 Port wr_bank, output, 1 bit: bank the camera writes; always equal to ~fb_bank.

Function
REQ-016 fb_rd_en SHALL equal data_req AND (pixel_addr < FRAME_PIXELS); the check is combinational, with zero cycles of added latency.
REQ-017 A valid shift pipeline of depth RD_LAT SHALL carry fb_rd_en.
REQ-018 pixel_data SHALL be registered and SHALL be updated RD_LAT cycles after a request: it takes fb_rd_data when the delayed valid bit is 1, and 12'h000 otherwise.
REQ-019 Out-of-range addresses and blanking cycles (data_req low) SHALL produce 12'h000 at the same latency as valid requests.
REQ-020 The bank FSM SHALL have three states: SHOW, SWAP_PEND and FROZEN.
REQ-021 In SHOW, wr_frame_done SHALL move the FSM to SWAP_PEND.
REQ-022 In SWAP_PEND, on the falling edge of vga_vs (registered-edge detect), the FSM SHALL toggle fb_bank and return to SHOW.
REQ-023 freeze=1 in either SHOW or SWAP_PEND SHALL move the FSM to FROZEN, and any pending swap SHALL be discarded.
REQ-024 In FROZEN, wr_frame_done SHALL be ignored.
REQ-025 When freeze falls to 0 in FROZEN, the FSM SHALL move to SHOW.
REQ-026 If wr_frame_done and the vs falling edge occur in the same cycle while in SHOW, the FSM SHALL enter SWAP_PEND only; the swap waits for the next frame edge.
REQ-027 If freeze and the vs falling edge occur in the same cycle while in SWAP_PEND, freeze SHALL win and no swap SHALL occur.
REQ-028 fb_bank SHALL change only at a vs falling edge, so bank changes never occur mid-frame.

Reset
REQ-029 While sys_rst_n=0, the following SHALL hold: pixel_data=0, the valid pipeline is all 0, fb_bank=0, FSM=SHOW, and the vs edge register=1.
REQ-030 Because fb_rd_en is combinational, it SHALL stay 0 during reset only if data_req=0.
REQ-031 On reset release mid-frame, no output SHALL be produced for requests issued before reset; data resumes RD_LAT cycles after the first post-reset request.

Configuration
REQ-032 With TEST_PATTERN_EN defined, an input port pattern_sel (1 bit) SHALL exist.
REQ-033 With TEST_PATTERN_EN defined and pattern_sel=1, valid pixels SHALL be replaced by eight vertical colour bars, each 80 pixels wide: column = pixel_addr mod 640, bar = column/80, colours in order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-034 With TEST_PATTERN_EN defined, the colour-bar output SHALL have the same RD_LAT latency and blanking behaviour as frame-buffer data.
REQ-035 With TEST_PATTERN_EN defined, fb_rd_en SHALL be suppressed while pattern_sel=1.
REQ-036 Without TEST_PATTERN_EN, the pattern_sel port and the pattern logic SHALL be absent, and output SHALL come from the frame buffer only.

Structure
REQ-037 Shared package vga_pkg SHALL hold H_ACT=640, V_ACT=480, FRAME_PIXELS, PIX_W=12, ADDR_W=19, and the bank FSM state enum.
REQ-038 One sub-module SHALL exist: vga_bank_ctrl, containing the FSM, the vs edge detect and fb_bank.
REQ-039 The top level SHALL contain the valid/data pipeline and the pattern logic.

Verification
REQ-040 RD_LAT=2; data_req=1 at addr 5; fb_rd_data=12'hABC two cycles later -> pixel_data=ABC registered 2 cycles after the request; fb_rd_addr=20'h00005.
REQ-041 data_req=1 at pixel_addr=307200 -> fb_rd_en=0; pixel_data=000 at the matching latency slot.
REQ-042 wr_frame_done pulse mid-frame -> fb_bank stays 0 until the next vga_vs falling edge, then becomes 1; wr_bank becomes 0.
REQ-043 freeze=1 before the vs edge while in SWAP_PEND -> no toggle; release freeze, then a further wr_frame_done and vs edge -> toggle.
REQ-044 Assert sys_rst_n=0 for 3 cycles during a stream of requests -> pixel_data=0 and fb_bank=0 immediately; the first valid output appears RD_LAT cycles after the first post-reset request.
REQ-045 TEST_PATTERN_EN with pattern_sel=1, addr 85 -> pixel_data=FF0; addr 639 -> 000; fb_rd_en=0 throughout.
